// File: rtl/instr_phase_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_phase_sequencer_if                                                   |
// | Handshake, instruction and phase-enable bundle of the phase sequencer.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface instr_phase_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic [15:0]      ir;
  logic             mem_ready;
  logic             fetch_en;
  logic             ir_load;
  logic             pc_inc;
  logic             alu_en;
  logic             mem_en;
  logic             wb_en;
  logic [2:0]       phase;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  start, stop, ir, mem_ready,
    output fetch_en, ir_load, pc_inc, alu_en, mem_en, wb_en,
           phase, halted, err, instr_count
  );

  modport slave (
    output start, stop, ir, mem_ready,
    input  fetch_en, ir_load, pc_inc, alu_en, mem_en, wb_en,
           phase, halted, err, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/instr_phase_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_phase_sequencer                                                      |
// | Multi-cycle FETCH/DECODE/EXEC/MEM/WB control with halt, stop and timeout.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module instr_phase_sequencer #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_phase_sequencer_if.master bus
);

  localparam int WAIT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam bit TIMEOUT_EN = (WAIT_MAX > 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic                stop_pend_q, stop_pend_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    instr_count_q, instr_count_d;

  logic                is_hlt;
  logic                need_mem;
  logic                mem_phase;
  logic                timeout;

  assign is_hlt   = (bus.ir[15:14] == 2'b11) && (bus.ir[7:4] == 4'b1111);
  assign need_mem = !bus.ir[15]
                 || (bus.ir[15:11] == 5'b10010)
                 || (bus.ir[15:11] == 5'b10011)
                 || (bus.ir[15:9]  == 7'b1011111);

  assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
  // The WAIT_MAX-th consecutive not-ready cycle is the one that trips the error.
  assign timeout   = TIMEOUT_EN && !bus.mem_ready && (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start && !bus.stop) state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready)          state_d = S_DECODE;
                else if (timeout)           state_d = S_ERR;
      S_DECODE: state_d = is_hlt   ? S_HALT : S_EXEC;
      S_EXEC:   state_d = need_mem ? S_MEM  : S_WB;
      S_MEM:    if (bus.mem_ready)          state_d = S_WB;
                else if (timeout)           state_d = S_ERR;
      S_WB:     state_d = (stop_pend_q || bus.stop) ? S_IDLE : S_FETCH;
      S_HALT:   if (stop_pend_q || bus.stop) state_d = S_IDLE;
                else if (bus.start)          state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_ERR;
    endcase
  end

  always_comb begin
    stop_pend_d = stop_pend_q;
    if (state_d == S_IDLE && state_q != S_IDLE)
      stop_pend_d = 1'b0;
    else if (bus.stop && state_q != S_IDLE)
      stop_pend_d = 1'b1;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (bus.mem_ready
        || ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))))
      wait_cnt_d = '0;
    else if (mem_phase)
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
  end

  always_comb begin
    instr_count_d = instr_count_q;
    if (state_q == S_WB)
      instr_count_d = instr_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      stop_pend_q   <= 1'b0;
      wait_cnt_q    <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stop_pend_q   <= stop_pend_d;
      wait_cnt_q    <= wait_cnt_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign bus.fetch_en    = (state_q == S_FETCH);
  assign bus.ir_load     = (state_q == S_FETCH) && bus.mem_ready;
  assign bus.pc_inc      = (state_q == S_DECODE);
  assign bus.alu_en      = (state_q == S_EXEC);
  assign bus.mem_en      = (state_q == S_MEM);
  assign bus.wb_en       = (state_q == S_WB);
  assign bus.phase       = state_q;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.err         = (state_q == S_ERR);
  assign bus.instr_count = instr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_phase_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instr_phase_sequencer                                                   |
// | Directed bench for the phase sequencer (timeout and counter-wrap variants).|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_instr_phase_sequencer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  instr_phase_sequencer_if #(.CNT_W(16)) b1();
  instr_phase_sequencer_if #(.CNT_W(2))  b2();

  instr_phase_sequencer #(.WAIT_MAX(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  instr_phase_sequencer #(.WAIT_MAX(0), .CNT_W(2)) dut_nto (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  // {fetch_en, ir_load, pc_inc, alu_en, mem_en, wb_en, halted, err}
  logic [7:0] flags;
  assign flags = {b1.fetch_en, b1.ir_load, b1.pc_inc, b1.alu_en,
                  b1.mem_en, b1.wb_en, b1.halted, b1.err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    b1.start = 1'b0; b1.stop = 1'b0; b1.mem_ready = 1'b1; b1.ir = 16'h0000;
    b2.start = 1'b0; b2.stop = 1'b0; b2.mem_ready = 1'b1; b2.ir = 16'h0000;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({b1.phase, flags} !== 11'h000) begin
      n_err++;
      $display("FAIL reset_outputs: phase/flags got %h want 000", {b1.phase, flags});
    end
    n_cmp++;
    if (b1.instr_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d want 0", b1.instr_count);
    end
  endtask

  task automatic test_add();
    logic [2:0] ph_seq [5];
    logic [2:0] exp_seq [5];
    int pc_hits;
    int alu_hits;
    exp_seq = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    pc_hits = 0;
    alu_hits = 0;
    apply_reset();
    b1.ir = 16'hC000; b1.mem_ready = 1'b1; b1.start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      b1.start = 1'b0;
      ph_seq[i] = b1.phase;
      pc_hits  += int'(b1.pc_inc);
      alu_hits += int'(b1.alu_en);
      if (i == 0) begin
        n_cmp++;
        if (flags !== 8'hC0) begin
          n_err++;
          $display("FAIL add_fetch_flags: got %h want c0", flags);
        end
      end
      if (i == 3) begin
        n_cmp++;
        if (flags !== 8'h04 || b1.instr_count !== 16'd0) begin
          n_err++;
          $display("FAIL add_wb: flags %h cnt %0d want 04 cnt 0", flags, b1.instr_count);
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (ph_seq[i] !== exp_seq[i]) begin
        n_err++;
        $display("FAIL add_phase[%0d]: got %0d want %0d", i, ph_seq[i], exp_seq[i]);
      end
    end
    n_cmp++;
    if (pc_hits != 1 || alu_hits != 1) begin
      n_err++;
      $display("FAIL add_pulses: pc_inc %0d alu_en %0d want 1 1", pc_hits, alu_hits);
    end
    n_cmp++;
    if (b1.instr_count !== 16'd1) begin
      n_err++;
      $display("FAIL add_count: got %0d want 1", b1.instr_count);
    end
  endtask

  task automatic test_ld_wait();
    int cycles;
    apply_reset();
    b1.ir = 16'h0000; b1.mem_ready = 1'b1; b1.start = 1'b1;
    tick(); b1.start = 1'b0; cycles = 1;  // FETCH
    tick(); cycles++;                     // DECODE
    tick(); cycles++;                     // EXEC
    b1.mem_ready = 1'b0;
    tick(); cycles++;                     // first MEM
    for (int i = 0; i < 4; i++) begin
      b1.mem_ready = (i == 3);
      n_cmp++;
      if (b1.phase !== 3'd4 || flags !== 8'h08) begin
        n_err++;
        $display("FAIL ld_mem[%0d]: phase %0d flags %h want 4 08", i, b1.phase, flags);
      end
      if (i < 3) begin
        tick(); cycles++;
      end
    end
    tick(); cycles++;                     // WB
    n_cmp++;
    if (b1.phase !== 3'd5 || cycles != 8) begin
      n_err++;
      $display("FAIL ld_latency: phase %0d cycles %0d want 5 8", b1.phase, cycles);
    end
    tick();
    n_cmp++;
    if (b1.instr_count !== 16'd1 || b1.phase !== 3'd1) begin
      n_err++;
      $display("FAIL ld_retire: cnt %0d phase %0d want 1 1", b1.instr_count, b1.phase);
    end
  endtask

  task automatic test_hlt();
    apply_reset();
    b1.ir = 16'hC0F0; b1.mem_ready = 1'b1; b1.start = 1'b1;
    tick(); b1.start = 1'b0;
    tick();
    tick();
    tick();
    n_cmp++;
    if (b1.phase !== 3'd6 || flags !== 8'h02 || b1.instr_count !== 16'd0) begin
      n_err++;
      $display("FAIL hlt_halt: phase %0d flags %h cnt %0d want 6 02 0",
               b1.phase, flags, b1.instr_count);
    end
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    n_cmp++;
    if (b1.phase !== 3'd1) begin
      n_err++;
      $display("FAIL hlt_restart: phase %0d want 1", b1.phase);
    end
    tick();
    tick();
    b1.stop = 1'b1;
    tick();
    b1.stop = 1'b0;
    n_cmp++;
    if (b1.phase !== 3'd0 || b1.halted !== 1'b0) begin
      n_err++;
      $display("FAIL hlt_stop: phase %0d halted %0b want 0 0", b1.phase, b1.halted);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    b1.ir = 16'hC000; b1.mem_ready = 1'b0; b1.start = 1'b1;
    tick(); b1.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (b1.phase !== 3'd1 || flags !== 8'h80) begin
        n_err++;
        $display("FAIL to_wait[%0d]: phase %0d flags %h want 1 80", i, b1.phase, flags);
      end
      tick();
    end
    n_cmp++;
    if (b1.phase !== 3'd7 || flags !== 8'h01) begin
      n_err++;
      $display("FAIL to_err: phase %0d flags %h want 7 01", b1.phase, flags);
    end
    b1.start = 1'b1; b1.mem_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (b1.phase !== 3'd7) begin
      n_err++;
      $display("FAIL to_sticky: phase %0d want 7", b1.phase);
    end
    apply_reset();
    n_cmp++;
    if (b1.phase !== 3'd0 || b1.err !== 1'b0) begin
      n_err++;
      $display("FAIL to_clear: phase %0d err %0b want 0 0", b1.phase, b1.err);
    end
  endtask

  task automatic test_stop();
    apply_reset();
    b1.ir = 16'hC000; b1.mem_ready = 1'b1; b1.start = 1'b1;
    tick(); b1.start = 1'b0;
    tick();
    tick();
    b1.stop = 1'b1;              // during EXEC
    tick();
    b1.stop = 1'b0;
    n_cmp++;
    if (b1.phase !== 3'd5) begin
      n_err++;
      $display("FAIL stop_wb: phase %0d want 5", b1.phase);
    end
    tick();
    n_cmp++;
    if (b1.phase !== 3'd0 || b1.instr_count !== 16'd1) begin
      n_err++;
      $display("FAIL stop_idle: phase %0d cnt %0d want 0 1", b1.phase, b1.instr_count);
    end
    b1.start = 1'b1; b1.stop = 1'b1;
    tick();
    n_cmp++;
    if (b1.phase !== 3'd0) begin
      n_err++;
      $display("FAIL stop_wins: phase %0d want 0", b1.phase);
    end
    b1.stop = 1'b0;
    tick();
    b1.start = 1'b0;
    n_cmp++;
    if (b1.phase !== 3'd1) begin
      n_err++;
      $display("FAIL stop_resume: phase %0d want 1", b1.phase);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    b1.ir = 16'hC000; b1.mem_ready = 1'b1; b1.start = 1'b1;
    tick(); b1.start = 1'b0;
    tick();
    tick();
    tick();
    b1.ir = 16'h0000;
    tick();
    tick();
    tick();
    b1.mem_ready = 1'b0;
    tick();
    n_cmp++;
    if (b1.phase !== 3'd4 || b1.instr_count !== 16'd1) begin
      n_err++;
      $display("FAIL ar_pre: phase %0d cnt %0d want 4 1", b1.phase, b1.instr_count);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({b1.phase, flags} !== 11'h000 || b1.instr_count !== 16'd0) begin
      n_err++;
      $display("FAIL ar_async: phase/flags %h cnt %0d want 000 0",
               {b1.phase, flags}, b1.instr_count);
    end
    tick();
    rst = 1'b0;
    b1.mem_ready = 1'b1;
  endtask

  task automatic test_wrap_no_timeout();
    apply_reset();
    b2.ir = 16'hC000; b2.mem_ready = 1'b0; b2.start = 1'b1;
    for (int i = 0; i < 21; i++) tick();
    n_cmp++;
    if (b2.phase !== 3'd1 || b2.err !== 1'b0) begin
      n_err++;
      $display("FAIL nto_hold: phase %0d err %0b want 1 0", b2.phase, b2.err);
    end
    b2.mem_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    n_cmp++;
    if (b2.instr_count !== 2'd3) begin
      n_err++;
      $display("FAIL nto_count3: got %0d want 3", b2.instr_count);
    end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (b2.instr_count !== 2'd0 || b2.phase !== 3'd1) begin
      n_err++;
      $display("FAIL nto_wrap: cnt %0d phase %0d want 0 1", b2.instr_count, b2.phase);
    end
    b2.start = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    test_reset();
    test_add();
    test_ld_wait();
    test_hlt();
    test_timeout();
    test_stop();
    test_async_reset();
    test_wrap_no_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
